ahb_mem_slv_if: RTL and testbench

- Parametrised AHB-Lite slave interface for single-port synchronous memories (ROM or SRAM), for the successor to the ROM-only bus interface.
- Adds the following:
  - byte/halfword/word writes with byte enables
  - configurable read wait states
  - read-only mode with a two-cycle ERROR response
  - a write-then-read port-conflict stall
- Sits between the AHB S->M mux and a ROM/SRAM macro. One instance per memory.

---
 rtl/ahb_mem_slv_if_if.sv | 23 ++
 rtl/ahb_mem_slv_if.sv | 147 ++++++++++++++
 tb/tb_ahb_mem_slv_if.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mem_slv_if_if.sv
// AHB-Lite slave-side bus bundle between the S->M mux and one memory slave.
interface ahb_mem_slv_if_if;
    logic        hsel;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_mem_slv_if.sv
// AHB-Lite slave front end for a single-port synchronous ROM/SRAM macro:
// byte-enabled writes, read wait states, read-only ERROR and write/read port stall.
module ahb_mem_slv_if #(
    parameter int p_AW   = 15,
    parameter int p_WAIT = 0,
    parameter bit p_RO   = 1'b1
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_mem_slv_if_if.slave     io_ahb,
    input  logic [31:0]         i_mem_rdata,
    output logic [p_AW-3:0]     o_mem_addr,
    output logic                o_mem_cs,
    output logic                o_mem_we,
    output logic [3:0]          o_mem_be,
    output logic [31:0]         o_mem_wdata
);

    localparam logic [2:0] LP_CNT_INIT = (p_WAIT > 0) ? 3'(p_WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_WR, S_ERR1, S_ERR2} state_t;

    state_t          r_state;
    logic [p_AW-3:0] r_addr;
    logic [3:0]      r_be;
    logic [2:0]      r_cnt;

    logic            w_acc;
    logic            w_bad;
    logic            w_conflict;
    logic [3:0]      w_be;
    logic [p_AW-3:0] w_waddr;
    logic            w_unused;

    logic            w_rdy;
    logic            w_err;
    logic            w_cs;
    logic            w_we;
    logic [3:0]      w_mbe;
    logic [p_AW-3:0] w_maddr;

    assign w_acc      = io_ahb.hsel & io_ahb.hready & io_ahb.htrans[1];
    assign w_bad      = (io_ahb.hsize > 3'd2)
                      | ((io_ahb.hsize == 3'd1) & io_ahb.haddr[0])
                      | ((io_ahb.hsize == 3'd2) & (io_ahb.haddr[1:0] != 2'b00))
                      | (io_ahb.hwrite & p_RO);
    // The port is busy writing, so a read arriving now must wait one cycle.
    assign w_conflict = io_ahb.hsel & io_ahb.htrans[1] & ~io_ahb.hwrite;
    assign w_waddr    = io_ahb.haddr[p_AW-1:2];
    assign w_unused   = ^{io_ahb.htrans[0], io_ahb.haddr[31:p_AW]};

    always_comb begin
        case (io_ahb.hsize)
            3'd0:    w_be = 4'b0001 << io_ahb.haddr[1:0];
            3'd1:    w_be = io_ahb.haddr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_rdy   = 1'b1;
        w_err   = 1'b0;
        w_cs    = 1'b0;
        w_we    = 1'b0;
        w_mbe   = 4'b0000;
        w_maddr = r_addr;
        case (r_state)
            S_IDLE: begin
                // Reads are issued straight from the address phase.
                w_cs    = w_acc & ~io_ahb.hwrite & ~w_bad;
                w_maddr = w_waddr;
            end
            S_RD_WAIT: begin
                w_rdy = 1'b0;
                w_cs  = 1'b1;
            end
            S_WR: begin
                w_rdy = ~w_conflict;
                w_cs  = 1'b1;
                w_we  = 1'b1;
                w_mbe = r_be;
            end
            S_ERR1: begin
                w_rdy = 1'b0;
                w_err = 1'b1;
            end
            S_ERR2:  w_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (w_bad) begin
                            r_state <= S_ERR1;
                        end else if (io_ahb.hwrite) begin
                            r_addr  <= w_waddr;
                            r_be    <= w_be;
                            r_state <= S_WR;
                        end else if (p_WAIT > 0) begin
                            r_addr  <= w_waddr;
                            r_cnt   <= LP_CNT_INIT;
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == 3'd0) r_state <= S_IDLE;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                S_WR: begin
                    if (w_conflict || !w_acc) begin
                        r_state <= S_IDLE;
                    end else if (w_bad) begin
                        r_state <= S_ERR1;
                    end else begin
                        r_addr  <= w_waddr;
                        r_be    <= w_be;
                        r_state <= S_WR;
                    end
                end
                S_ERR1:  r_state <= S_ERR2;
                // Whatever is presented here is cancelled by the master.
                S_ERR2:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_ahb.hreadyout = w_rdy;
    assign io_ahb.hresp     = {1'b0, w_err};
    assign io_ahb.hrdata    = i_mem_rdata;
    assign o_mem_cs         = w_cs;
    assign o_mem_we         = w_we;
    assign o_mem_be         = w_mbe;
    assign o_mem_addr       = w_maddr;
    assign o_mem_wdata      = io_ahb.hwdata;

endmodule

// File: tb/tb_ahb_mem_slv_if.sv
// Bench for ahb_mem_slv_if: ROM (no wait), SRAM (no wait) and SRAM (3 waits) instances
// driven one at a time, each with a behavioural memory behind it.
module tb_ahb_mem_slv_if;

    localparam logic [1:0] NS = 2'b10;

    logic hclk;
    logic hresetn;

    ahb_mem_slv_if_if bus [3] ();

    logic [2:0]        t_hsel;
    logic [2:0][1:0]   t_htrans;
    logic [2:0][2:0]   t_hsize;
    logic [2:0]        t_hwrite;
    logic [2:0][31:0]  t_haddr;
    logic [2:0][31:0]  t_hwdata;

    logic [2:0]        a_rdy;
    logic [2:0][1:0]   a_resp;
    logic [2:0][31:0]  a_rdata;
    logic [2:0]        m_cs;
    logic [2:0]        m_we;
    logic [2:0][12:0]  m_addr;
    logic [2:0][3:0]   m_be;
    logic [2:0][31:0]  m_wdata;
    logic [2:0][31:0]  m_rdata;

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign bus[g].hsel   = t_hsel[g];
        assign bus[g].htrans = t_htrans[g];
        assign bus[g].hsize  = t_hsize[g];
        assign bus[g].hwrite = t_hwrite[g];
        assign bus[g].haddr  = t_haddr[g];
        assign bus[g].hwdata = t_hwdata[g];
        assign bus[g].hready = bus[g].hreadyout;
        assign a_rdy[g]      = bus[g].hreadyout;
        assign a_resp[g]     = bus[g].hresp;
        assign a_rdata[g]    = bus[g].hrdata;
    end

    ahb_mem_slv_if #(.p_AW(15), .p_WAIT(0), .p_RO(1'b1)) u_ro (
        .hclk(hclk), .hresetn(hresetn), .io_ahb(bus[0].slave),
        .i_mem_rdata(m_rdata[0]), .o_mem_addr(m_addr[0]), .o_mem_cs(m_cs[0]),
        .o_mem_we(m_we[0]), .o_mem_be(m_be[0]), .o_mem_wdata(m_wdata[0]));

    ahb_mem_slv_if #(.p_AW(15), .p_WAIT(0), .p_RO(1'b0)) u_rw (
        .hclk(hclk), .hresetn(hresetn), .io_ahb(bus[1].slave),
        .i_mem_rdata(m_rdata[1]), .o_mem_addr(m_addr[1]), .o_mem_cs(m_cs[1]),
        .o_mem_we(m_we[1]), .o_mem_be(m_be[1]), .o_mem_wdata(m_wdata[1]));

    ahb_mem_slv_if #(.p_AW(15), .p_WAIT(3), .p_RO(1'b0)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .io_ahb(bus[2].slave),
        .i_mem_rdata(m_rdata[2]), .o_mem_addr(m_addr[2]), .o_mem_cs(m_cs[2]),
        .o_mem_we(m_we[2]), .o_mem_be(m_be[2]), .o_mem_wdata(m_wdata[2]));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Unwritten words read back as 0xA5_<instance>_<word address>.
    bit [31:0] mem   [3][256];
    bit        mvld  [3][256];

    function automatic logic [31:0] pat(input int g, input logic [7:0] a);
        return 32'hA500_0000 | (32'(g) << 16) | 32'(a);
    endfunction

    always @(posedge hclk) begin
        for (int g = 0; g < 3; g++) begin
            if (m_cs[g]) begin
                if (m_we[g]) begin
                    logic [31:0] w;
                    w = mvld[g][m_addr[g][7:0]] ? mem[g][m_addr[g][7:0]] : pat(g, m_addr[g][7:0]);
                    for (int b = 0; b < 4; b++)
                        if (m_be[g][b]) w[8*b +: 8] = m_wdata[g][8*b +: 8];
                    mem[g][m_addr[g][7:0]]  <= w;
                    mvld[g][m_addr[g][7:0]] <= 1'b1;
                end else begin
                    m_rdata[g] <= mvld[g][m_addr[g][7:0]] ? mem[g][m_addr[g][7:0]]
                                                          : pat(g, m_addr[g][7:0]);
                end
            end
        end
    end

    typedef struct {
        int          d;
        string       nm;
        logic        rdy;
        logic [1:0]  rsp;
        logic        cs;
        logic        we;
        logic [12:0] ad;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          crd;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic ex(input int d, input string nm, input logic rdy, input logic [1:0] rsp,
                      input logic cs, input logic we, input logic [12:0] ad, input logic [3:0] be,
                      input logic [31:0] wd, input bit crd, input logic [31:0] rd);
        exp_t e;
        e.d = d; e.nm = nm; e.rdy = rdy; e.rsp = rsp; e.cs = cs; e.we = we;
        e.ad = ad; e.be = be; e.wd = wd; e.crd = crd; e.rd = rd;
        q.push_back(e);
    endtask

    // Monitor: every record queued for a cycle is checked mid-cycle.
    always @(negedge hclk) begin
        while (q.size() > 0) begin
            exp_t e;
            bit   ok;
            e  = q.pop_front();
            ok = (a_rdy[e.d] === e.rdy) && (a_resp[e.d] === e.rsp)
              && (m_cs[e.d] === e.cs) && (m_we[e.d] === e.we)
              && (!e.cs || m_addr[e.d] === e.ad)
              && (!e.we || (m_be[e.d] === e.be && m_wdata[e.d] === e.wd))
              && (!e.crd || a_rdata[e.d] === e.rd);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s: got rdy=%b resp=%b cs=%b we=%b addr=%h be=%b wd=%h rd=%h, need rdy=%b resp=%b cs=%b we=%b addr=%h be=%b wd=%h rd=%h",
                         e.nm, a_rdy[e.d], a_resp[e.d], m_cs[e.d], m_we[e.d], m_addr[e.d],
                         m_be[e.d], m_wdata[e.d], a_rdata[e.d],
                         e.rdy, e.rsp, e.cs, e.we, e.ad, e.be, e.wd, e.rd);
            end
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_all();
        t_hsel   = '0;
        t_htrans = '0;
        t_hwrite = '0;
    endtask

    task automatic drv(input int d, input logic [2:0] sz, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
        idle_all();
        t_hsel[d]   = 1'b1;
        t_htrans[d] = NS;
        t_hsize[d]  = sz;
        t_hwrite[d] = wr;
        t_haddr[d]  = a;
        t_hwdata[d] = wd;
    endtask

    // Address phase already driven; checks the two ERROR cycles and the OKAY after.
    task automatic err_seq(input int d, input string nm);
        ex(d, {nm, "_addr"}, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
        idle_all();
        ex(d, {nm, "_err1"}, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0); step();
        ex(d, {nm, "_err2"}, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0); step();
        ex(d, {nm, "_okay"}, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    endtask

    task automatic rd3(input logic [31:0] a, input logic [31:0] dat, input string nm);
        logic [12:0] wa;
        wa = a[14:2];
        drv(2, 3'd2, 1'b0, a, 32'h0);
        ex(2, {nm, "_addr"}, 1, 2'b00, 1, 0, wa, 0, 0, 0, 0); step();
        idle_all();
        for (int i = 0; i < 3; i++) begin
            ex(2, {nm, "_wait"}, 0, 2'b00, 1, 0, wa, 0, 0, 0, 0); step();
        end
        ex(2, {nm, "_data"}, 1, 2'b00, 0, 0, 0, 0, 0, 1, dat); step();
    endtask

    initial begin
        repeat (5000) @(posedge hclk);
        $display("FAIL watchdog: got no finish within 5000 cycles, need end of sequence");
        $fatal(1);
    end

    initial begin
        hresetn  = 1'b0;
        t_hsize  = '0;
        t_haddr  = '0;
        t_hwdata = '0;
        idle_all();
        step();
        for (int d = 0; d < 3; d++) ex(d, "reset", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step();
        hresetn = 1'b1;
        step();

        // ROM zero-wait word read at 0x10
        drv(0, 3'd2, 1'b0, 32'h10, 32'h0);
        ex(0, "ro_rd_addr", 1, 2'b00, 1, 0, 13'h4, 0, 0, 0, 0); step();
        idle_all();
        ex(0, "ro_rd_data", 1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hA500_0004); step();

        // ROM write gets a two-cycle ERROR
        drv(0, 3'd2, 1'b1, 32'h20, 32'h0);
        err_seq(0, "ro_wr");

        // SRAM byte write 0xAB at 0x103, then read the word back
        drv(1, 3'd0, 1'b1, 32'h103, 32'h0);
        ex(1, "rw_bw_addr", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
        idle_all();
        t_hwdata[1] = 32'hAB00_0000;
        ex(1, "rw_bw_data", 1, 2'b00, 1, 1, 13'h40, 4'b1000, 32'hAB00_0000, 0, 0); step();
        drv(1, 3'd2, 1'b0, 32'h100, 32'h0);
        ex(1, "rw_rd_addr", 1, 2'b00, 1, 0, 13'h40, 0, 0, 0, 0); step();
        idle_all();
        ex(1, "rw_rd_data", 1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hAB01_0040); step();

        // SRAM write 0x8 followed immediately by read 0x8
        drv(1, 3'd2, 1'b1, 32'h8, 32'h0);
        ex(1, "rw_cf_addr", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
        drv(1, 3'd2, 1'b0, 32'h8, 32'h1234_5678);
        ex(1, "rw_cf_wr", 0, 2'b00, 1, 1, 13'h2, 4'b1111, 32'h1234_5678, 0, 0); step();
        ex(1, "rw_cf_rd", 1, 2'b00, 1, 0, 13'h2, 0, 0, 0, 0); step();
        idle_all();
        ex(1, "rw_cf_data", 1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h1234_5678); step();

        // Misaligned halfword and illegal size
        drv(1, 3'd1, 1'b0, 32'h1, 32'h0);
        err_seq(1, "mis_half");
        drv(1, 3'd3, 1'b0, 32'h0, 32'h0);
        err_seq(1, "size3");

        // Three wait states, back-to-back reads at 0x20 and 0x24
        drv(2, 3'd2, 1'b0, 32'h20, 32'h0);
        ex(2, "w3_a0", 1, 2'b00, 1, 0, 13'h8, 0, 0, 0, 0); step();
        drv(2, 3'd2, 1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 3; i++) begin
            ex(2, "w3_wait0", 0, 2'b00, 1, 0, 13'h8, 0, 0, 0, 0); step();
        end
        ex(2, "w3_d0_a1", 1, 2'b00, 1, 0, 13'h9, 0, 0, 1, 32'hA502_0008); step();
        idle_all();
        for (int i = 0; i < 3; i++) begin
            ex(2, "w3_wait1", 0, 2'b00, 1, 0, 13'h9, 0, 0, 0, 0); step();
        end
        ex(2, "w3_d1", 1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hA502_0009); step();

        // Reset while in RD_WAIT, then a normal read
        drv(2, 3'd2, 1'b0, 32'h20, 32'h0);
        ex(2, "rst_rd_addr", 1, 2'b00, 1, 0, 13'h8, 0, 0, 0, 0); step();
        idle_all();
        hresetn = 1'b0;
        ex(2, "rst_in_wait", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
        hresetn = 1'b1;
        ex(2, "rst_after", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
        rd3(32'h24, 32'hA502_0009, "rst_rd");

        repeat (2) @(posedge hclk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unchecked records, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
